// File: rtl/dac_sample_generator.sv
// Sample generator for the SPI DAC adapter: a phase accumulator stepped on a divided
// sample tick, a two-stage waveform pipeline and a VALID/READY output register.
module dac_sample_generator #(
    parameter int CLK_DIV = 3200,
    parameter int PHASE_W = 16
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               ENABLE,
    input  logic [1:0]         MODE,
    input  logic [PHASE_W-1:0] FREQ_WORD,
    input  logic               READY,
    input  logic               CLEAR_OVR,
    output logic [11:0]        SAMPLE,
    output logic               VALID,
    output logic               OVERRUN,
    output logic [PHASE_W-1:0] PHASE
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_SAW = 2'd0,
        MODE_TRI = 2'd1,
        MODE_SQR = 2'd2,
        MODE_SIN = 2'd3
    } mode_e;

    // First quadrant, sampled at bin centres so the quadrant folds are symmetric.
    localparam logic [10:0] SINE_ROM [64] = '{
        11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
        11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
        11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
        11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
        11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
        11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
        11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
        11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
    };

    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic               s1_vld_q,   s1_vld_d;
    mode_e              s1_mode_q,  s1_mode_d;
    logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
    logic [11:0]        sample_q,   sample_d;
    logic               valid_q,    valid_d;
    logic               ovr_q,      ovr_d;

    logic        tick;
    logic [1:0]  quad;
    logic [5:0]  idx;
    logic [5:0]  rom_addr;
    logic [10:0] rom_val;
    logic [11:0] mapped;

    always_comb begin
        tick       = ENABLE && (cnt_q == CNT_LAST);
        cnt_d      = (ENABLE && !tick) ? cnt_q + 1'b1 : '0;
        phase_d    = tick ? phase_q + FREQ_WORD : phase_q;
        s1_vld_d   = tick;
        s1_mode_d  = tick ? mode_e'(MODE) : s1_mode_q;
        s1_phase_d = tick ? phase_d : s1_phase_q;
    end

    // Quadrants 1 and 3 read the table backwards; 63-idx is the bitwise inverse.
    always_comb begin
        quad     = s1_phase_q[PHASE_W-1 -: 2];
        idx      = s1_phase_q[PHASE_W-3 -: 6];
        rom_addr = quad[0] ? ~idx : idx;
        rom_val  = SINE_ROM[rom_addr];
        mapped   = 12'h800;
        case (s1_mode_q)
            MODE_SAW: mapped = s1_phase_q[PHASE_W-1 -: 12];
            MODE_TRI: mapped = s1_phase_q[PHASE_W-1] ? ~s1_phase_q[PHASE_W-2 -: 12]
                                                     :  s1_phase_q[PHASE_W-2 -: 12];
            MODE_SQR: mapped = s1_phase_q[PHASE_W-1] ? 12'h000 : 12'hFFF;
            MODE_SIN: mapped = quad[1] ? (12'd2047 - {1'b0, rom_val})
                                       : (12'd2048 + {1'b0, rom_val});
            default:  mapped = 12'h800;
        endcase
    end

    // A load overrides the clear from a same-edge transfer; an overrun overrides CLEAR_OVR.
    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (valid_q && READY) begin
            valid_d = 1'b0;
        end
        if (CLEAR_OVR) begin
            ovr_d = 1'b0;
        end
        if (s1_vld_q) begin
            sample_d = mapped;
            valid_d  = 1'b1;
            if (valid_q && !READY) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q      <= '0;
            phase_q    <= '0;
            s1_vld_q   <= 1'b0;
            s1_mode_q  <= MODE_SAW;
            s1_phase_q <= '0;
            sample_q   <= 12'h800;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            s1_vld_q   <= s1_vld_d;
            s1_mode_q  <= s1_mode_d;
            s1_phase_q <= s1_phase_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign SAMPLE  = sample_q;
    assign VALID   = valid_q;
    assign OVERRUN = ovr_q;
    assign PHASE   = phase_q;

endmodule

// File: tb/tb_dac_sample_generator.sv
// Scoreboard bench for dac_sample_generator: stimulus queues the samples it expects to be
// accepted, a negedge monitor pops and compares on every VALID&&READY transfer.
module tb_dac_sample_generator;

    localparam int DIV = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        enable    = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic [15:0] freq      = 16'h0000;
    logic        ready     = 1'b0;
    logic        clear_ovr = 1'b0;
    logic [11:0] sample;
    logic        valid;
    logic        overrun;
    logic [15:0] phase;

    int          checks   = 0;
    int          failures = 0;
    logic [11:0] exp_q [$];
    logic [11:0] mon_exp;

    dac_sample_generator #(.CLK_DIV(DIV), .PHASE_W(16)) dut (
        .CLOCK    (clk),
        .RESET_N  (rst_n),
        .ENABLE   (enable),
        .MODE     (mode),
        .FREQ_WORD(freq),
        .READY    (ready),
        .CLEAR_OVR(clear_ovr),
        .SAMPLE   (sample),
        .VALID    (valid),
        .OVERRUN  (overrun),
        .PHASE    (phase)
    );

    always #5 clk = ~clk;

    initial assert (DIV >= 2) else $fatal(1, "CLK_DIV below legal minimum of 2");

    initial begin
        #300000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sample_unexpected actual=%03h required=no_transfer", sample);
            end else begin
                mon_exp = exp_q.pop_front();
                if (sample !== mon_exp) begin
                    failures++;
                    $display("FAIL sample actual=%03h required=%03h", sample, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    // Reset lands between clock edges; outputs must change without waiting for a clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        enable    = 1'b0;
        ready     = 1'b0;
        clear_ovr = 1'b0;
        #1;
        check("rst_sample",  sample,  12'h800);
        check("rst_valid",   valid,   1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_phase",   phase,   16'h0000);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic run_ticks(input int n);
        enable = 1'b1;
        repeat (n * DIV) @(posedge clk);
        #1;
        enable = 1'b0;
        cycles(3);
    endtask

    function automatic int rom_ref(input int i);
        real a;
        a = 2047.0 * $sin((real'(i) + 0.5) * 3.141592653589793 / 128.0);
        return int'($floor(a + 0.5));
    endfunction

    function automatic logic [11:0] sine_ref(input logic [15:0] p);
        int idx;
        idx = int'(p[13:8]);
        case (p[15:14])
            2'd0:    return 12'(2048 + rom_ref(idx));
            2'd1:    return 12'(2048 + rom_ref(63 - idx));
            2'd2:    return 12'(2047 - rom_ref(idx));
            default: return 12'(2047 - rom_ref(63 - idx));
        endcase
    endfunction

    initial begin
        logic [11:0] tri_v [4];
        logic [11:0] sqr_v [4];
        logic [11:0] sin_v [4];
        int          lat;
        tri_v = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
        sqr_v = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};
        sin_v = '{12'd4095, 12'd2022, 12'd0, 12'd2073};

        // sawtooth ramp with wrap
        do_reset();
        mode = 2'd0; freq = 16'h1000; ready = 1'b1;
        for (int k = 1; k <= 16; k++) exp_q.push_back(12'(k * 256));
        run_ticks(16);
        check_drained("saw");
        check("saw_phase_wrap", phase, 16'h0000);

        // triangle and square at quarter-cycle steps
        do_reset();
        mode = 2'd1; freq = 16'h4000; ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(tri_v[k % 4]);
        run_ticks(8);
        check_drained("tri");

        do_reset();
        mode = 2'd2; freq = 16'h4000; ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(sqr_v[k % 4]);
        run_ticks(8);
        check_drained("sqr");

        // sine: quadrant corners, then a full 256-step sweep
        do_reset();
        mode = 2'd3; freq = 16'h4000; ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(sin_v[k % 4]);
        run_ticks(8);
        check_drained("sin_corners");

        do_reset();
        mode = 2'd3; freq = 16'h0100; ready = 1'b1;
        for (int k = 1; k <= 256; k++) exp_q.push_back(sine_ref(16'(k * 256)));
        run_ticks(256);
        check_drained("sin_sweep");

        // overrun: three loads with READY low, latest sample wins
        do_reset();
        mode = 2'd0; freq = 16'h1000; ready = 1'b0;
        exp_q.push_back(12'h300);
        enable = 1'b1;
        cycles(6);
        check("ovr_after_first", overrun, 1'b0);
        check("valid_held",      valid,   1'b1);
        cycles(4);
        check("ovr_after_second", overrun, 1'b1);
        cycles(2);
        enable = 1'b0;
        cycles(1);
        ready = 1'b1;
        cycles(2);
        check("valid_after_accept", valid,   1'b0);
        check("ovr_sticky",         overrun, 1'b1);
        check_drained("ovr");
        clear_ovr = 1'b1;
        cycles(1);
        clear_ovr = 1'b0;
        check("ovr_cleared", overrun, 1'b0);

        // overrun and CLEAR_OVR on the same edge: set wins
        ready = 1'b0;
        exp_q.push_back(12'h500);
        enable = 1'b1;
        cycles(6);
        check("ovr_no_conflict", overrun, 1'b0);
        cycles(2);
        enable    = 1'b0;
        clear_ovr = 1'b1;
        cycles(1);
        clear_ovr = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        ready = 1'b1;
        cycles(2);
        check_drained("ovr_same_edge");

        // ENABLE dropped while a sample waits; latency counts the first edge seeing ENABLE=1 as 1
        do_reset();
        mode = 2'd0; freq = 16'h1000; ready = 1'b0;
        enable = 1'b1;
        cycles(DIV);
        enable = 1'b0;
        cycles(1);
        check("dis_valid_set", valid, 1'b1);
        cycles(8);
        check("dis_phase_frozen", phase, 16'h1000);
        check("dis_valid_held",   valid, 1'b1);
        exp_q.push_back(12'h100);
        ready = 1'b1;
        cycles(2);
        check("dis_valid_accepted", valid, 1'b0);
        check_drained("dis_first");
        exp_q.push_back(12'h200);
        enable = 1'b1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            cycles(1);
            if (valid) begin
                lat = n;
                break;
            end
        end
        enable = 1'b0;
        check("reenable_latency", lat, DIV + 1);
        cycles(2);
        check_drained("dis_second");

        // asynchronous reset mid-count and mid-handshake, then restart
        do_reset();
        mode = 2'd0; freq = 16'h1000; ready = 1'b0;
        enable = 1'b1;
        cycles(10);
        check("pre_reset_valid",   valid,   1'b1);
        check("pre_reset_overrun", overrun, 1'b1);
        do_reset();
        mode = 2'd0; freq = 16'h1000; ready = 1'b1;
        exp_q.push_back(12'h100);
        exp_q.push_back(12'h200);
        run_ticks(2);
        check_drained("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
